// File: rtl/writeback_regfile_if.sv
// Writeback-stage bus between the MEM/WB register and the register file.
// Master drives the writeback result and read addresses; slave returns data.
interface writeback_regfile_if #(
  parameter int CNT_W = 32
);
  logic             RegWriteW;
  logic             MemtoRegW;
  logic [31:0]      ReadDataW;
  logic [31:0]      ALUOutW;
  logic [4:0]       WriteRegW;
  logic [4:0]       A1;
  logic [4:0]       A2;
  logic [31:0]      RD1;
  logic [31:0]      RD2;
  logic [31:0]      ResultW;
  logic [CNT_W-1:0] RetireCount;

  modport master (
    output RegWriteW,
    output MemtoRegW,
    output ReadDataW,
    output ALUOutW,
    output WriteRegW,
    output A1,
    output A2,
    input  RD1,
    input  RD2,
    input  ResultW,
    input  RetireCount
  );

  modport slave (
    input  RegWriteW,
    input  MemtoRegW,
    input  ReadDataW,
    input  ALUOutW,
    input  WriteRegW,
    input  A1,
    input  A2,
    output RD1,
    output RD2,
    output ResultW,
    output RetireCount
  );
endinterface

// File: rtl/writeback_regfile.sv
// 31x32 register file with writeback result mux, optional write-to-read
// forwarding and a retired-write counter.
module writeback_regfile #(
  parameter int BYPASS = 1,
  parameter int CNT_W  = 32
) (
  input logic               clk,
  input logic               rst,
  writeback_regfile_if.slave wb
);

  logic [31:0]      rf [1:31];
  logic [31:0]      result;
  logic [CNT_W-1:0] cnt;
  logic             we;
  logic             fwd1;
  logic             fwd2;
  logic [31:0]      rd1;
  logic [31:0]      rd2;

  assign result = wb.MemtoRegW ? wb.ReadDataW
                               : wb.ALUOutW;
  assign we     = wb.RegWriteW &&
                  (wb.WriteRegW != 5'd0);

  // Forwarding stays live during reset so a
  // valid ResultW is still visible.
  assign fwd1 = (BYPASS != 0) && we &&
                (wb.WriteRegW == wb.A1);
  assign fwd2 = (BYPASS != 0) && we &&
                (wb.WriteRegW == wb.A2);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 1; i < 32; i++) begin
        rf[i] <= '0;
      end
      cnt <= '0;
    end else if (we) begin
      rf[wb.WriteRegW] <= result;
      cnt              <= cnt + CNT_W'(1);
    end
  end

  always_comb begin
    rd1 = '0;
    unique case (1'b1)
      (wb.A1 == 5'd0): rd1 = '0;
      fwd1:            rd1 = result;
      default:         rd1 = rf[wb.A1];
    endcase
  end

  always_comb begin
    rd2 = '0;
    unique case (1'b1)
      (wb.A2 == 5'd0): rd2 = '0;
      fwd2:            rd2 = result;
      default:         rd2 = rf[wb.A2];
    endcase
  end

  assign wb.RD1         = rd1;
  assign wb.RD2         = rd2;
  assign wb.ResultW     = result;
  assign wb.RetireCount = cnt;

endmodule

// File: tb/tb_writeback_regfile.sv
// Random plus directed bench for writeback_regfile against an array model;
// covers bypass on/off and a 4-bit retire counter.
module tb_writeback_regfile;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rw  = 1'b0;
  logic        m2r = 1'b0;
  logic [31:0] rdat = '0;
  logic [31:0] alu  = '0;
  logic [4:0]  wr = '0;
  logic [4:0]  a1 = '0;
  logic [4:0]  a2 = '0;

  logic [31:0] mreg [32];
  logic [31:0] mcnt;
  int          n_chk  = 0;
  int          n_pass = 0;

  writeback_regfile_if #(.CNT_W(32)) ifb ();
  writeback_regfile_if #(.CNT_W(32)) ifn ();
  writeback_regfile_if #(.CNT_W(4))  ifc ();

  assign ifb.RegWriteW = rw;
  assign ifb.MemtoRegW = m2r;
  assign ifb.ReadDataW = rdat;
  assign ifb.ALUOutW   = alu;
  assign ifb.WriteRegW = wr;
  assign ifb.A1        = a1;
  assign ifb.A2        = a2;
  assign ifn.RegWriteW = rw;
  assign ifn.MemtoRegW = m2r;
  assign ifn.ReadDataW = rdat;
  assign ifn.ALUOutW   = alu;
  assign ifn.WriteRegW = wr;
  assign ifn.A1        = a1;
  assign ifn.A2        = a2;
  assign ifc.RegWriteW = rw;
  assign ifc.MemtoRegW = m2r;
  assign ifc.ReadDataW = rdat;
  assign ifc.ALUOutW   = alu;
  assign ifc.WriteRegW = wr;
  assign ifc.A1        = a1;
  assign ifc.A2        = a2;

  writeback_regfile #(.BYPASS(1), .CNT_W(32)) dut_b (
    .clk(clk), .rst(rst), .wb(ifb)
  );
  writeback_regfile #(.BYPASS(0), .CNT_W(32)) dut_n (
    .clk(clk), .rst(rst), .wb(ifn)
  );
  writeback_regfile #(.BYPASS(1), .CNT_W(4)) dut_c (
    .clk(clk), .rst(rst), .wb(ifc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    else
      n_pass++;
  endtask

  function automatic logic [31:0] exp_res();
    return m2r ? rdat : alu;
  endfunction

  function automatic logic [31:0] exp_rd(
    input logic [4:0] a, input bit byp);
    if (a == 5'd0) return '0;
    if (byp && rw && wr != 5'd0 && wr == a)
      return exp_res();
    return mreg[a];
  endfunction

  task automatic model_reset();
    foreach (mreg[i]) mreg[i] = '0;
    mcnt = '0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".res"},  ifb.ResultW, exp_res());
    chk({tag, ".rd1b"}, ifb.RD1, exp_rd(a1, 1'b1));
    chk({tag, ".rd2b"}, ifb.RD2, exp_rd(a2, 1'b1));
    chk({tag, ".rd1n"}, ifn.RD1, exp_rd(a1, 1'b0));
    chk({tag, ".rd2n"}, ifn.RD2, exp_rd(a2, 1'b0));
    chk({tag, ".cnt"},  ifb.RetireCount, mcnt);
    chk({tag, ".cnt4"}, 32'(ifc.RetireCount),
        32'(mcnt[3:0]));
  endtask

  // Check before the edge, then apply the commit rule to the model.
  task automatic step(input string tag);
    #1 check_all(tag);
    @(posedge clk);
    if (rst && rw && wr != 5'd0) begin
      mreg[wr] = exp_res();
      mcnt++;
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic w, input logic m,
                       input logic [31:0] rd,
                       input logic [31:0] al,
                       input logic [4:0] d,
                       input logic [4:0] r1,
                       input logic [4:0] r2);
    rw = w; m2r = m; rdat = rd; alu = al;
    wr = d; a1 = r1; a2 = r2;
  endtask

  initial begin
    model_reset();
    drive(1'b0, 1'b0, '0, '0, 5'd0, 5'd5, 5'd31);
    @(negedge clk);
    #1 chk("rst.rd1", ifb.RD1, 32'h0);
    chk("rst.rd2", ifb.RD2, 32'h0);
    chk("rst.cnt", ifb.RetireCount, 32'h0);
    step("reset");
    rst = 1'b1;

    drive(1'b1, 1'b0, '0, 32'h1234_5678, 5'd7, 5'd0, 5'd0);
    step("w7");
    drive(1'b0, 1'b0, '0, '0, 5'd0, 5'd7, 5'd0);
    #1 chk("w7.rd1", ifn.RD1, 32'h1234_5678);
    chk("w7.cnt", ifb.RetireCount, 32'd1);
    step("r7");

    drive(1'b1, 1'b1, 32'hDEAD_BEEF, '0, 5'd0, 5'd0, 5'd0);
    step("w0");
    drive(1'b0, 1'b0, '0, '0, 5'd0, 5'd0, 5'd7);
    #1 chk("w0.rd1", ifb.RD1, 32'h0);
    chk("w0.cnt", ifb.RetireCount, 32'd1);
    step("r0");

    drive(1'b1, 1'b0, '0, 32'h11, 5'd9, 5'd0, 5'd0);
    step("w9a");
    drive(1'b1, 1'b0, '0, 32'h22, 5'd9, 5'd9, 5'd9);
    #1 chk("byp.rd1b", ifb.RD1, 32'h22);
    chk("byp.rd2b", ifb.RD2, 32'h22);
    chk("byp.rd1n", ifn.RD1, 32'h11);
    chk("byp.rd2n", ifn.RD2, 32'h11);
    step("w9b");
    drive(1'b0, 1'b0, '0, '0, 5'd0, 5'd9, 5'd9);
    #1 chk("byp.after", ifn.RD1, 32'h22);
    step("r9");

    for (int i = 0; i < 300; i++) begin
      logic [4:0] d;
      d = 5'($urandom_range(0, 7));
      drive($urandom_range(0, 3) != 0,
            1'($urandom),
            $urandom, $urandom, d,
            ($urandom_range(0, 2) == 0) ? d
              : 5'($urandom_range(0, 31)),
            ($urandom_range(0, 2) == 0) ? d
              : 5'($urandom_range(0, 31)));
      step("rand");
    end

    // Reset asserted mid-cycle with a write pending.
    drive(1'b1, 1'b0, '0, 32'h33, 5'd3, 5'd0, 5'd0);
    step("w3");
    drive(1'b1, 1'b0, '0, 32'h44, 5'd4, 5'd0, 5'd0);
    step("w4");
    drive(1'b1, 1'b0, '0, 32'h55, 5'd3, 5'd3, 5'd4);
    #2 rst = 1'b0;
    model_reset();
    #1 chk("arst.rd1n", ifn.RD1, 32'h0);
    chk("arst.rd2n", ifn.RD2, 32'h0);
    chk("arst.rd2b", ifb.RD2, 32'h0);
    chk("arst.cnt", ifb.RetireCount, 32'h0);
    step("arst");
    drive(1'b0, 1'b0, '0, '0, 5'd0, 5'd3, 5'd4);
    #2 rst = 1'b1;
    #1 chk("arst.lost", ifb.RD1, 32'h0);
    chk("arst.cnt2", ifb.RetireCount, 32'h0);
    step("arst.rel");

    // 4-bit counter wrap after a fresh reset.
    rst = 1'b0;
    model_reset();
    #1 rst = 1'b1;
    for (int i = 0; i < 15; i++) begin
      drive(1'b1, 1'b0, '0, $urandom,
            5'(1 + i), 5'(i), 5'(i + 2));
      step("wrap");
    end
    #1 chk("wrap.15", 32'(ifc.RetireCount), 32'd15);
    drive(1'b1, 1'b1, 32'hA5A5_0001, '0,
          5'd31, 5'd31, 5'd1);
    step("wrap.16");
    drive(1'b0, 1'b0, '0, '0, 5'd0, 5'd31, 5'd1);
    #1 chk("wrap.0", 32'(ifc.RetireCount), 32'd0);
    chk("wrap.32", ifb.RetireCount, 32'd16);
    step("final");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
